demux_1_4_buf: RTL and testbench
================================

Name: demux_1_4_buf

Overview:
Registered 1-to-4 demultiplexer for the datapath. It steers one input word, selected by SEL, into one of four single-entry output buffers. Each output channel has its own valid/ready handshake. It is the distribution end of the 4-way selection path: it fans a producer (ALU result or bus word) out to one of four consumers (register write ports, output latches) and absorbs per-consumer back-pressure.

Parameters:
DataPathSize, 3, width of data words on input and all outputs
CH0 / CH1 / CH2 / CH3, 2'b00 / 2'b01 / 2'b10 / 2'b11, SEL encodings for channels 0..3

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
IN_DATA  input  DataPathSize  word to distribute
SEL  input  2  destination channel, sampled with IN_DATA
IN_VALID  input  1  producer has a word
IN_READY  output  1  block accepts the word this cycle
OUT0..OUT3  output  DataPathSize each  channel data (registered)
OUT_VALID  output  4  bit k: channel k holds a word
OUT_READY  input  4  bit k: consumer k takes the word this cycle
BUSY  output  1  OR of OUT_VALID

Behaviour:
- Reset (async, RST=1): all OUTk=0, OUT_VALID=4'b0000, BUSY=0, IN_READY follows its combinational rule with all slots empty.
- Each channel is a one-entry slot with states EMPTY and FULL.
- Input acceptance: accept = IN_VALID & IN_READY.
- IN_READY = !OUT_VALID[SEL] | OUT_READY[SEL]. This is combinational from SEL, OUT_VALID and OUT_READY; there is no path from IN_VALID.
- Output transfer on channel k: drain_k = OUT_VALID[k] & OUT_READY[k].
- Slot k transitions at the clock edge:
  - EMPTY + accept with SEL=k -> FULL; OUTk<=IN_DATA.
  - FULL + drain_k without load -> EMPTY; OUTk holds its last value.
  - FULL + drain_k + accept with SEL=k -> stays FULL; OUTk<=IN_DATA (back-to-back, no bubble).
  - FULL + !OUT_READY[k] -> holds. IN_READY is low for SEL=k.
- Latency: a word accepted at edge n appears on OUTk with OUT_VALID[k]=1 after edge n, i.e. 1 cycle.
- At most one slot is loaded per cycle. Any number of slots may drain in the same cycle.
- Non-selected channels are unaffected by the input, and they may drain while the input is stalled on another channel.
- OUT_VALID[k] stays asserted until drained. OUTk is stable while OUT_VALID[k]=1 and no reload occurs.
- OUT_READY[k] while slot k is EMPTY is ignored.
- SEL and IN_DATA are don't-care when IN_VALID=0. No state changes on that input.
- Reset mid-operation discards every pending word immediately; no partial transfer is reported.
- All four SEL values are legal; there is no error condition.

Decomposition:
- Shared package holds:
  - CH0..CH3 select encodings, common to all 4-way select/distribute logic.
  - The default DataPathSize.
- Natural sub-module: demux_slot, a one-entry buffer with load, data_in, ready_out, valid, data_out and CLK/RST, parameterised by DataPathSize. The top instantiates it 4 times.
- The top holds the SEL decode, the IN_READY mux and the BUSY OR.

Test Plan:
- Reset: assert RST mid-simulation with slots 1 and 3 FULL -> immediately OUT_VALID=0000, OUT1=OUT3=0, BUSY=0.
- Basic routing: IN_DATA=3'b101, SEL=2'b10, IN_VALID=1, OUT_READY=0000 -> after 1 edge OUT2=101, OUT_VALID=0100, other outputs unchanged.
- Back-pressure: slot 2 FULL with OUT_READY[2]=0, then present SEL=2'b10 -> IN_READY=0 and the word is held. Raise OUT_READY[2] -> IN_READY=1 the same cycle; the next edge replaces OUT2 and OUT_VALID[2] stays 1.
- Non-blocking: slot 0 FULL and stalled, send 3'b011 on SEL=2'b01 -> accepted, OUT1=011, OUT_VALID=0011.
- Streaming: SEL=2'b11 with OUT_READY[3]=1 held, 4 consecutive words 1,2,3,4 -> one accepted per cycle, IN_READY always 1, OUT3 sequence 1,2,3,4 with no bubble.
- Simultaneous drain: all slots FULL, OUT_READY=1111, IN_VALID=0 -> after 1 edge OUT_VALID=0000 and BUSY=0.

Source files
------------

// File: rtl/demux_1_4_buf_pkg.sv
// Shared definitions for the 4-way select/distribute datapath: channel
// encodings, default word width and the one-entry slot state type.
package demux_1_4_buf_pkg;

   localparam int DATA_PATH_SIZE = 3;

   localparam logic [1:0] CH0 = 2'b00;
   localparam logic [1:0] CH1 = 2'b01;
   localparam logic [1:0] CH2 = 2'b10;
   localparam logic [1:0] CH3 = 2'b11;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // One-hot channel mask for a select code; bit k set means channel k.
   function automatic logic [3:0] sel_decode(input logic [1:0] sel);
      sel_decode = 4'b0000;
      case (sel)
         CH0:     sel_decode = 4'b0001;
         CH1:     sel_decode = 4'b0010;
         CH2:     sel_decode = 4'b0100;
         CH3:     sel_decode = 4'b1000;
         default: sel_decode = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/demux_1_4_buf_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-4 distributor.
interface demux_1_4_buf_if
   import demux_1_4_buf_pkg::*;
#(
   parameter int DataPathSize = DATA_PATH_SIZE
);

   logic [DataPathSize-1:0] IN_DATA;
   logic [1:0]              SEL;
   logic                    IN_VALID;
   logic                    IN_READY;
   logic [DataPathSize-1:0] OUT0;
   logic [DataPathSize-1:0] OUT1;
   logic [DataPathSize-1:0] OUT2;
   logic [DataPathSize-1:0] OUT3;
   logic [3:0]              OUT_VALID;
   logic [3:0]              OUT_READY;
   logic                    BUSY;

   modport master (
      output IN_DATA, SEL, IN_VALID, OUT_READY,
      input  IN_READY, OUT0, OUT1, OUT2, OUT3, OUT_VALID, BUSY
   );

   modport slave (
      input  IN_DATA, SEL, IN_VALID, OUT_READY,
      output IN_READY, OUT0, OUT1, OUT2, OUT3, OUT_VALID, BUSY
   );

endinterface

// File: rtl/demux_1_4_buf_slot.sv
// One-entry output buffer: EMPTY/FULL slot that loads a word and releases it
// when its consumer is ready; a load on a draining slot refills without a bubble.
module demux_slot
   import demux_1_4_buf_pkg::*;
#(
   parameter int DataPathSize = DATA_PATH_SIZE
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    load_i,
   input  logic [DataPathSize-1:0] data_i,
   input  logic                    ready_out_i,
   output logic                    valid_o,
   output logic [DataPathSize-1:0] data_o
);

   slot_state_e             state_q, state_d;
   logic [DataPathSize-1:0] data_q,  data_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case can leave it unassigned and infer a latch.
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (load_i) begin
               state_d = SLOT_FULL;
               data_d  = data_i;
            end
         end
         SLOT_FULL: begin
            if (load_i) begin
               data_d = data_i;
            end else if (ready_out_i) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   // NOTE: the data register is reset too, because consumers observe the
   // word lines directly and must see zero after reset, not stale contents.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together
         // from pre-edge values regardless of statement order.
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = (state_q == SLOT_FULL);
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 demultiplexer: steers one word per cycle into one of four
// single-entry slots, each with its own valid/ready handshake.
module demux_1_4_buf
   import demux_1_4_buf_pkg::*;
#(
   parameter int DataPathSize = DATA_PATH_SIZE
) (
   input  logic            CLK,
   input  logic            RST,
   demux_1_4_buf_if.slave  bus
);

   logic [3:0]              sel_onehot;
   logic [3:0]              slot_ready;
   logic [3:0]              slot_load;
   logic [3:0]              slot_valid;
   logic [DataPathSize-1:0] slot_data [4];
   logic                    accept;

   assign sel_onehot = sel_decode(bus.SEL);

   // A slot can take a word when it is empty or is being drained this cycle.
   assign slot_ready   = ~slot_valid | bus.OUT_READY;
   assign bus.IN_READY = |(sel_onehot & slot_ready);

   assign accept    = bus.IN_VALID & bus.IN_READY;
   assign slot_load = accept ? sel_onehot : 4'b0000;

   for (genvar k = 0; k < 4; k++) begin : g_slot
      demux_slot #(
         .DataPathSize (DataPathSize)
      ) u_slot (
         .CLK         (CLK),
         .RST         (RST),
         .load_i      (slot_load[k]),
         .data_i      (bus.IN_DATA),
         .ready_out_i (bus.OUT_READY[k]),
         .valid_o     (slot_valid[k]),
         .data_o      (slot_data[k])
      );
   end

   assign bus.OUT0      = slot_data[0];
   assign bus.OUT1      = slot_data[1];
   assign bus.OUT2      = slot_data[2];
   assign bus.OUT3      = slot_data[3];
   assign bus.OUT_VALID = slot_valid;
   assign bus.BUSY      = |slot_valid;

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Self-checking bench for demux_1_4_buf: directed scenarios with literal
// expectations plus randomized traffic against a slot-array reference model.
module tb_demux_1_4_buf;
   import demux_1_4_buf_pkg::*;

   localparam int W = DATA_PATH_SIZE;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   demux_1_4_buf_if #(.DataPathSize(W)) bus ();

   demux_1_4_buf #(.DataPathSize(W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Reference model: each channel is simply "holds a word or not" plus the word.
   bit           m_full [4];
   logic [W-1:0] m_data [4];
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 1'b0;
         m_data[k] = '0;
      end
   endtask

   function automatic logic model_in_ready();
      int s;
      s = int'(bus.SEL);
      return !m_full[s] || bus.OUT_READY[s];
   endfunction

   task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [3:0] rdy);
      bus.IN_VALID  = v;
      bus.SEL       = sel;
      bus.IN_DATA   = d;
      bus.OUT_READY = rdy;
   endtask

   // Advance one clock: update the model from pre-edge state, land on the negedge.
   task automatic cycle();
      logic acc;
      @(posedge CLK);
      acc = bus.IN_VALID && model_in_ready();
      for (int k = 0; k < 4; k++) begin
         if (acc && int'(bus.SEL) == k) begin
            m_full[k] = 1'b1;
            m_data[k] = bus.IN_DATA;
         end else if (m_full[k] && bus.OUT_READY[k]) begin
            m_full[k] = 1'b0;
         end
      end
      @(negedge CLK);
   endtask

   task automatic compare_all(input string tag);
      logic [3:0]   ev;
      logic [W-1:0] got [4];
      got[0] = bus.OUT0;
      got[1] = bus.OUT1;
      got[2] = bus.OUT2;
      got[3] = bus.OUT3;
      for (int k = 0; k < 4; k++) begin
         ev[k] = m_full[k];
         check($sformatf("%s.OUT%0d", tag, k), 32'(got[k]), 32'(m_data[k]));
      end
      check({tag, ".OUT_VALID"}, 32'(bus.OUT_VALID), 32'(ev));
      check({tag, ".BUSY"}, 32'(bus.BUSY), 32'(|ev));
      check({tag, ".IN_READY"}, 32'(bus.IN_READY), 32'(model_in_ready()));
   endtask

   initial begin
      // Reset state.
      RST = 1'b1;
      drive(1'b0, 2'b00, '0, 4'b0000);
      model_reset();
      #2;
      check("rst.OUT_VALID", 32'(bus.OUT_VALID), 32'h0);
      check("rst.BUSY", 32'(bus.BUSY), 32'h0);
      check("rst.IN_READY", 32'(bus.IN_READY), 32'h1);
      check("rst.OUT0", 32'(bus.OUT0), 32'h0);
      @(negedge CLK);
      RST = 1'b0;

      // Basic routing to channel 2.
      drive(1'b1, 2'b10, 3'b101, 4'b0000);
      #1 check("route.IN_READY", 32'(bus.IN_READY), 32'h1);
      cycle();
      check("route.OUT2", 32'(bus.OUT2), 32'h5);
      check("route.OUT_VALID", 32'(bus.OUT_VALID), 32'h4);
      check("route.OUT0", 32'(bus.OUT0), 32'h0);
      compare_all("route");

      // Back-pressure on channel 2, then release and reload in the same edge.
      drive(1'b1, 2'b10, 3'b110, 4'b0000);
      #1 check("bp.IN_READY_low", 32'(bus.IN_READY), 32'h0);
      cycle();
      check("bp.OUT2_held", 32'(bus.OUT2), 32'h5);
      check("bp.OUT_VALID", 32'(bus.OUT_VALID), 32'h4);
      bus.OUT_READY = 4'b0100;
      #1 check("bp.IN_READY_high", 32'(bus.IN_READY), 32'h1);
      cycle();
      check("bp.OUT2_new", 32'(bus.OUT2), 32'h6);
      check("bp.OUT_VALID_kept", 32'(bus.OUT_VALID), 32'h4);
      compare_all("bp");

      // Load channel 0 while draining channel 2, then send past the stalled slot 0.
      drive(1'b1, 2'b00, 3'b001, 4'b0100);
      cycle();
      check("nb.OUT_VALID0", 32'(bus.OUT_VALID), 32'h1);
      drive(1'b1, 2'b01, 3'b011, 4'b0000);
      #1 check("nb.IN_READY", 32'(bus.IN_READY), 32'h1);
      cycle();
      check("nb.OUT1", 32'(bus.OUT1), 32'h3);
      check("nb.OUT_VALID", 32'(bus.OUT_VALID), 32'h3);
      compare_all("nb");

      // Streaming 1,2,3,4 into channel 3 with the consumer always ready.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 2'b11, W'(i), 4'b1000);
         #1 check($sformatf("stream%0d.IN_READY", i), 32'(bus.IN_READY), 32'h1);
         cycle();
         check($sformatf("stream%0d.OUT3", i), 32'(bus.OUT3), 32'(i));
         check($sformatf("stream%0d.OUT_VALID", i), 32'(bus.OUT_VALID), 32'hB);
      end

      // Fill channel 2, then drain all four at once.
      drive(1'b1, 2'b10, 3'b111, 4'b0000);
      cycle();
      check("fill.OUT_VALID", 32'(bus.OUT_VALID), 32'hF);
      drive(1'b0, 2'b00, 3'b000, 4'b1111);
      cycle();
      check("drain.OUT_VALID", 32'(bus.OUT_VALID), 32'h0);
      check("drain.BUSY", 32'(bus.BUSY), 32'h0);
      compare_all("drain");

      // Asynchronous reset with slots 1 and 3 full.
      drive(1'b1, 2'b01, 3'b101, 4'b0000);
      cycle();
      drive(1'b1, 2'b11, 3'b110, 4'b0000);
      cycle();
      check("pre_rst.OUT_VALID", 32'(bus.OUT_VALID), 32'hA);
      drive(1'b0, 2'b00, 3'b000, 4'b0000);
      #2 RST = 1'b1;
      #1;
      check("arst.OUT_VALID", 32'(bus.OUT_VALID), 32'h0);
      check("arst.OUT1", 32'(bus.OUT1), 32'h0);
      check("arst.OUT3", 32'(bus.OUT3), 32'h0);
      check("arst.BUSY", 32'(bus.BUSY), 32'h0);
      model_reset();
      @(negedge CLK);
      RST = 1'b0;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 9) < 7), 2'($urandom), W'($urandom), 4'($urandom));
         #1 compare_all("rand");
         cycle();
      end
      compare_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
